disp_share_arbiter: RTL and testbench

//  Shares the 4-digit 7-seg sweep display between NREQ requesters. Round-robin arbiter with

---
 rtl/disp_share_pkg.sv | 17 +
 rtl/disp_share_arbiter_rr_pick.sv | 30 +++
 rtl/disp_share_arbiter.sv | 117 +++++++++++
 tb/tb_disp_share_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/disp_share_pkg.sv
// Shared types and constants for the display-sharing arbiters.
package disp_share_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   localparam int NDIGITS = 4;
   localparam int DIGIT_W = 4;
   localparam int WORD_W  = NDIGITS * DIGIT_W;

   function automatic int owner_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/disp_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after owner_i, wrapping, owner_i last.
module rr_pick
   import disp_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int OW   = owner_w(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [OW-1:0]   owner_i,
   output logic            found_o,
   output logic [OW-1:0]   idx_o
);

   always_comb begin
      int c;
      c       = 0;
      found_o = 1'b0;
      idx_o   = owner_i;
      // Walk farthest-to-nearest so the closest candidate is written last and wins.
      for (int k = NREQ; k >= 1; k--) begin
         c = int'(owner_i) + k;
         if (c >= NREQ) c = c - NREQ;
         if (req_i[OW'(c)]) begin
            found_o = 1'b1;
            idx_o   = OW'(c);
         end
      end
   end

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin sharing of the 4-digit sweep display with a minimum hold per owner.
// Define DISP_PREEMPT_EN to make requester 0 a preempting priority source.
module disp_share_arbiter
   import disp_share_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int NBITS_HOLD = 28,
   parameter int HOLD       = 100_000_000,
   localparam int OW        = owner_w(NREQ)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NREQ-1:0]        req_i,
   input  logic [WORD_W*NREQ-1:0] data_i,
   output logic [NREQ-1:0]        gnt_o,
   output logic [OW-1:0]          owner_o,
   output logic                   busy_o,
   output logic [DIGIT_W-1:0]     disp0_o,
   output logic [DIGIT_W-1:0]     disp1_o,
   output logic [DIGIT_W-1:0]     disp2_o,
   output logic [DIGIT_W-1:0]     disp3_o
);

   state_e                            state_q, state_d;
   logic [OW-1:0]                     owner_q, owner_d;
   logic [NBITS_HOLD-1:0]             cnt_q, cnt_d;
   logic [NREQ-1:0]                   gnt_q, gnt_d;
   logic [NDIGITS-1:0][DIGIT_W-1:0]   disp_q, disp_d;

   logic          rr_found;
   logic [OW-1:0] rr_idx;
   logic          sel_found;
   logic [OW-1:0] sel_idx;
   logic          expire;
   logic          decide;

   rr_pick #(
      .NREQ (NREQ),
      .OW   (OW)
   ) u_disp_rr_pick (
      .req_i   (req_i),
      .owner_i (owner_q),
      .found_o (rr_found),
      .idx_o   (rr_idx)
   );

   always_comb begin
      sel_found = rr_found;
      sel_idx   = rr_idx;
`ifdef DISP_PREEMPT_EN
      // Requester 0 wins every arbitration it takes part in, including keeping its own grant.
      if (req_i[0]) begin
         sel_found = 1'b1;
         sel_idx   = '0;
      end
`endif
   end

   always_comb begin
      expire = (cnt_q == NBITS_HOLD'(HOLD - 1)) || !req_i[owner_q];
      decide = 1'b1;
      if (state_q == ST_HOLD) begin
`ifdef DISP_PREEMPT_EN
         decide = expire || (req_i[0] && (owner_q != '0));
`else
         decide = expire;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      gnt_d   = '0;
      if (!decide) begin
         cnt_d  = cnt_q + 1'b1;
         disp_d = data_i[WORD_W*owner_q +: WORD_W];
      end else if (sel_found) begin
         state_d = ST_HOLD;
         owner_d = sel_idx;
         cnt_d   = '0;
         disp_d  = data_i[WORD_W*sel_idx +: WORD_W];
      end else begin
         // Nobody left: release the display but leave the last digits showing.
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
      if (state_d == ST_HOLD) gnt_d = NREQ'(1) << owner_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         owner_q <= OW'(NREQ - 1);
         cnt_q   <= '0;
         gnt_q   <= '0;
         disp_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         disp_q  <= disp_d;
      end
   end

   assign gnt_o   = gnt_q;
   assign owner_o = owner_q;
   assign busy_o  = (state_q == ST_HOLD);
   assign disp0_o = disp_q[0];
   assign disp1_o = disp_q[1];
   assign disp2_o = disp_q[2];
   assign disp3_o = disp_q[3];

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter (NREQ=4, HOLD=4) with a per-cycle reference model.
module tb_disp_share_arbiter;

   localparam int NREQ = 4;
   localparam int HOLD = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  req   = 4'b0;
   logic [63:0] data;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        busy;
   logic [3:0]  d0, d1, d2, d3;

   int errors = 0;
   int checks = 0;

   disp_share_arbiter #(
      .NREQ       (NREQ),
      .NBITS_HOLD (28),
      .HOLD       (HOLD)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req_i   (req),
      .data_i  (data),
      .gnt_o   (gnt),
      .owner_o (owner),
      .busy_o  (busy),
      .disp0_o (d0),
      .disp1_o (d1),
      .disp2_o (d2),
      .disp3_o (d3)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the display, how long they have held it, what is shown.
   int          m_owner;
   bit          m_busy;
   int          m_held;
   logic [15:0] m_disp;

   always @(posedge clk or negedge rst_n) begin
      bit pre;
      bit decide;
      int nxt;
      if (!rst_n) begin
         m_owner = NREQ - 1;
         m_busy  = 0;
         m_held  = 0;
         m_disp  = 16'h0;
      end else begin
         pre = 0;
`ifdef DISP_PREEMPT_EN
         pre = req[0];
`endif
         decide = !m_busy || (m_held == HOLD - 1) || !req[m_owner] || (pre && m_owner != 0);
         if (decide) begin
            nxt = -1;
            if (pre) nxt = 0;
            else
               for (int d = 1; d <= NREQ; d++)
                  if (nxt < 0 && req[(m_owner + d) % NREQ]) nxt = (m_owner + d) % NREQ;
            if (nxt >= 0) begin
               m_owner = nxt;
               m_busy  = 1;
               m_held  = 0;
               m_disp  = data[16*nxt +: 16];
            end else begin
               m_busy = 0;
            end
         end else begin
            m_held = m_held + 1;
            m_disp = data[16*m_owner +: 16];
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] eg;
      eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      checks++;
      if ({gnt, owner, busy, d3, d2, d1, d0} !== {eg, 2'(m_owner), m_busy, m_disp}) begin
         errors++;
         $display("FAIL model t=%0t: got gnt=%b owner=%0d busy=%b disp=%h, expected gnt=%b owner=%0d busy=%b disp=%h",
                  $time, gnt, owner, busy, {d3, d2, d1, d0}, eg, m_owner, m_busy, m_disp);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      data = {16'h9EF0, 16'h1234, 16'h5678, 16'hABCD};
      #1 rst_n = 1'b0;
      tick(2);
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_owner", owner, 2'd3);
      chk("rst_disp", {d3, d2, d1, d0}, 16'h0000);
      rst_n = 1'b1;
      tick(1);

      // Round-robin from owner 3 over 0,1,3, each held HOLD cycles
      req = 4'b1011;
      tick(1); chk("rr_g0", gnt, 4'b0001); chk("rr_own0", owner, 2'd0); chk("rr_disp0", {d3, d2, d1, d0}, 16'hABCD);
      tick(3); chk("rr_g0_end", gnt, 4'b0001);
      tick(1); chk("rr_g1", gnt, 4'b0010); chk("rr_disp1", {d3, d2, d1, d0}, 16'h5678);
      tick(3); chk("rr_g1_end", gnt, 4'b0010);
      tick(1); chk("rr_g3", gnt, 4'b1000);
      tick(3); chk("rr_g3_end", gnt, 4'b1000);
      tick(1); chk("rr_g0_again", gnt, 4'b0001);

      // Owner 1 drops at cnt=1 while 3 waits, then everyone leaves
      tick(3);
      tick(1); chk("drop_g1", gnt, 4'b0010);
      tick(1);
      req = 4'b1000;
      tick(1); chk("drop_g3", gnt, 4'b1000); chk("drop_own3", owner, 2'd3); chk("drop_disp", {d3, d2, d1, d0}, 16'h9EF0);
      req = 4'b0000;
      tick(1); chk("idle_busy", busy, 1'b0); chk("idle_gnt", gnt, 4'b0000); chk("idle_own", owner, 2'd3);
      tick(2); chk("idle_disp", {d3, d2, d1, d0}, 16'h9EF0);

      // Lone requester 2 keeps the display across hold restarts
      req = 4'b0100;
      tick(1); chk("solo_g2", gnt, 4'b0100); chk("solo_disp", {d3, d2, d1, d0}, 16'h1234);
      tick(1); chk("solo_disp2", {d3, d2, d1, d0}, 16'h1234);
      tick(10); chk("solo_keep", gnt, 4'b0100); chk("solo_busy", busy, 1'b1);
      data[47:32] = 16'h4321;
      tick(1); chk("solo_dlat", {d3, d2, d1, d0}, 16'h4321);
      req = 4'b0000;
      tick(1); chk("solo_idle", busy, 1'b0); chk("solo_idle_own", owner, 2'd2);

      // Requester 0 arrives while 2 is at cnt=1
      req = 4'b0100;
      tick(1); chk("pre_g2", gnt, 4'b0100);
      tick(1);
      req = 4'b0101;
`ifdef DISP_PREEMPT_EN
      tick(1); chk("pre_g0", gnt, 4'b0001); chk("pre_own0", owner, 2'd0);
      tick(12); chk("pre_keep0", gnt, 4'b0001);
      req = 4'b0100;
      tick(1); chk("pre_back2", gnt, 4'b0100);
`else
      tick(1); chk("nopre_cnt2", gnt, 4'b0100);
      tick(1); chk("nopre_cnt3", gnt, 4'b0100);
      tick(1); chk("nopre_g0", gnt, 4'b0001); chk("nopre_own0", owner, 2'd0);
`endif

      // Asynchronous reset mid-hold
      req = 4'b1111;
      tick(3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_gnt", gnt, 4'b0000);
      chk("arst_busy", busy, 1'b0);
      chk("arst_owner", owner, 2'd3);
      chk("arst_disp", {d3, d2, d1, d0}, 16'h0000);
      tick(1);
      rst_n = 1'b1;
      tick(1); chk("post_rst_g0", gnt, 4'b0001);
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
